// File: rtl/mmio_bus_interconnect.sv
// mmio_bus_interconnect
//   Data-side interconnect between the RV32IM load/store port and up to
//   eight memory-mapped slaves (DMEM, GPIO, UART, timer). Each slave owns
//   an address region decoded as (addr & mask) == base. Slaves may stall
//   with s_ready. A decode miss or a stalled access produces a bus-error
//   response carrying ERR_RDATA.
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   m_req/m_we/m_addr/m_wdata/m_wstrb
//                    master request and payload (held until m_ready)
//   m_ready          one-cycle response pulse
//   m_rdata, m_err   registered read data and error flag, valid with m_ready
//   s_req            one-hot slave request
//   s_we/s_addr/s_wdata/s_wstrb
//                    latched payload; s_addr is the in-region offset
//   s_ready, s_rdata per-slave completion and read data
//
// Optional build macro BUS_ERR_CAPTURE_EN adds err_clr, err_valid,
// err_addr and err_is_timeout: the first bus error is recorded until it
// is cleared.
module mmio_bus_interconnect #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
    {32'h1000_0200, 32'h1000_0100, 32'h1000_0000, 32'h0000_8000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK =
    {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_8000},
  parameter int TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_req,
  input  logic                         m_we,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_wstrb,
  output logic                         m_ready,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_req,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata
`ifdef BUS_ERR_CAPTURE_EN
  ,
  input  logic                         err_clr,
  output logic                         err_valid,
  output logic [ADDR_W-1:0]            err_addr,
  output logic                         err_is_timeout
`endif
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;

  logic                    hit;
  logic [NUM_SLAVES-1:0]   hit_onehot;
  logic [ADDR_W-1:0]       hit_off;
  logic                    sel_ready;
  logic [DATA_W-1:0]       sel_rdata;
  logic                    timeout_hit;

  // Parallel region decode; scanning upward and keeping the first match
  // gives the lowest index priority on overlapping regions.
  always_comb begin
    hit        = 1'b0;
    hit_onehot = '0;
    hit_off    = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                   SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        hit           = 1'b1;
        hit_onehot[i] = 1'b1;
        hit_off       = m_addr & ~SLV_MASK[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // The registered one-hot s_req doubles as the latched slave index, so
  // ready/rdata from non-selected slaves are masked off here.
  always_comb begin
    sel_ready = |(s_ready & s_req);
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (s_req[i]) sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
    end
  end

  // cnt holds the number of completed ACCESS cycles; the current cycle is
  // the last allowed one when it equals TIMEOUT_CYCLES-1.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      s_req   <= '0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      m_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_req) begin
            if (hit) begin
              s_req   <= hit_onehot;
              s_we    <= m_we;
              s_addr  <= hit_off;
              s_wdata <= m_wdata;
              s_wstrb <= m_wstrb;
              cnt     <= '0;
              state   <= ACCESS;
            end else begin
              m_ready <= 1'b1;
              m_err   <= 1'b1;
              m_rdata <= ERR_RDATA;
              state   <= RESP;
            end
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            s_req   <= '0;
            m_ready <= 1'b1;
            m_err   <= 1'b0;
            m_rdata <= s_we ? '0 : sel_rdata;
            state   <= RESP;
          end else if (timeout_hit) begin
            s_req   <= '0;
            m_ready <= 1'b1;
            m_err   <= 1'b1;
            m_rdata <= ERR_RDATA;
            state   <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          m_ready <= 1'b0;
          m_err   <= 1'b0;
          cnt     <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUS_ERR_CAPTURE_EN
  // Full master address of the transfer in flight; s_addr only carries
  // the in-region offset.
  logic [ADDR_W-1:0] addr_q;
  logic              err_evt;
  logic              err_evt_to;
  logic [ADDR_W-1:0] err_evt_addr;

  always_comb begin
    err_evt      = 1'b0;
    err_evt_to   = 1'b0;
    err_evt_addr = '0;
    if (state == IDLE && m_req && !hit) begin
      err_evt      = 1'b1;
      err_evt_addr = m_addr;
    end else if (state == ACCESS && !sel_ready && timeout_hit) begin
      err_evt      = 1'b1;
      err_evt_to   = 1'b1;
      err_evt_addr = addr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q         <= '0;
      err_valid      <= 1'b0;
      err_addr       <= '0;
      err_is_timeout <= 1'b0;
    end else begin
      if (state == IDLE && m_req && hit) addr_q <= m_addr;
      // A clear in the same cycle as a new error re-arms the capture and
      // the new error is recorded.
      if (err_evt && (!err_valid || err_clr)) begin
        err_valid      <= 1'b1;
        err_addr       <= err_evt_addr;
        err_is_timeout <= err_evt_to;
      end else if (err_clr) begin
        err_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mmio_bus_interconnect.sv
// Directed testbench for mmio_bus_interconnect (default 4-slave map).
// Inputs are driven 1 time unit after each rising edge; outputs are
// checked at the same point.
module tb_mmio_bus_interconnect;

  logic         clk;
  logic         reset;
  logic         m_req;
  logic         m_we;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic         m_err;
  logic [3:0]   s_req;
  logic         s_we;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;
`ifdef BUS_ERR_CAPTURE_EN
  logic         err_clr;
  logic         err_valid;
  logic [31:0]  err_addr;
  logic         err_is_timeout;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mmio_bus_interconnect dut (
    .clk     (clk),
    .reset   (reset),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_ready (m_ready),
    .m_rdata (m_rdata),
    .m_err   (m_err),
    .s_req   (s_req),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_ready (s_ready),
    .s_rdata (s_rdata)
`ifdef BUS_ERR_CAPTURE_EN
    ,
    .err_clr        (err_clr),
    .err_valid      (err_valid),
    .err_addr       (err_addr),
    .err_is_timeout (err_is_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_ready = '0;
    s_rdata = '0;
`ifdef BUS_ERR_CAPTURE_EN
    err_clr = 1'b0;
`endif
    tick();
    tick();
    check("rst_s_req",   s_req,   4'h0);
    check("rst_m_ready", m_ready, 1'b0);
    check("rst_m_err",   m_err,   1'b0);
    check("rst_m_rdata", m_rdata, 32'h0);
    check("rst_s_addr",  s_addr,  32'h0);
    check("rst_s_we",    s_we,    1'b0);
`ifdef BUS_ERR_CAPTURE_EN
    check("rst_err_valid", err_valid, 1'b0);
`endif
    reset = 1'b0;
    tick();

    // 1: zero-wait read from slave 0
    s_rdata[31:0]   = 32'h1234_5678;
    s_rdata[63:32]  = 32'hFFFF_0001;
    s_rdata[95:64]  = 32'hCAFE_0002;
    s_rdata[127:96] = 32'h3333_0003;
    s_ready = 4'b0001;
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_8010;
    check("t1_c0_ready", m_ready, 1'b0);
    tick();
    check("t1_c1_s_req",  s_req,   4'b0001);
    check("t1_c1_s_addr", s_addr,  32'h10);
    check("t1_c1_s_we",   s_we,    1'b0);
    check("t1_c1_ready",  m_ready, 1'b0);
    tick();
    check("t1_c2_ready", m_ready, 1'b1);
    check("t1_c2_rdata", m_rdata, 32'h1234_5678);
    check("t1_c2_err",   m_err,   1'b0);
    check("t1_c2_s_req", s_req,   4'b0000);
    m_req = 1'b0;
    tick();
    check("t1_c3_ready", m_ready, 1'b0);
    check("t1_c3_rdata_hold", m_rdata, 32'h1234_5678);

    // 2: write to slave 1 with 3 wait states; other slaves' ready ignored
    s_ready = 4'b0000;
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h1000_0004;
    m_wdata = 32'hA5A5_A5A5; m_wstrb = 4'hF;
    tick();
    check("t2_c1_s_req",   s_req,   4'b0010);
    check("t2_c1_s_addr",  s_addr,  32'h4);
    check("t2_c1_s_wdata", s_wdata, 32'hA5A5_A5A5);
    check("t2_c1_s_wstrb", s_wstrb, 4'hF);
    check("t2_c1_s_we",    s_we,    1'b1);
    s_ready = 4'b1101;
    tick();
    check("t2_c2_s_req", s_req,   4'b0010);
    check("t2_c2_ready", m_ready, 1'b0);
    tick();
    check("t2_c3_s_req", s_req,   4'b0010);
    check("t2_c3_ready", m_ready, 1'b0);
    tick();
    check("t2_c4_s_req", s_req,   4'b0010);
    check("t2_c4_ready", m_ready, 1'b0);
    s_ready = 4'b0010;
    tick();
    check("t2_c5_ready", m_ready, 1'b1);
    check("t2_c5_err",   m_err,   1'b0);
    check("t2_c5_rdata", m_rdata, 32'h0);
    check("t2_c5_s_req", s_req,   4'b0000);
    m_req = 1'b0; m_we = 1'b0; s_ready = 4'b0000;
    tick();
    check("t2_c6_ready", m_ready, 1'b0);

    // 3: decode miss
    m_req = 1'b1; m_addr = 32'h2000_0000;
    tick();
    check("t3_c1_ready", m_ready, 1'b1);
    check("t3_c1_err",   m_err,   1'b1);
    check("t3_c1_rdata", m_rdata, 32'hDEAD_BEEF);
    check("t3_c1_s_req", s_req,   4'b0000);
    m_req = 1'b0;
    tick();
    check("t3_c2_ready", m_ready, 1'b0);
    check("t3_c2_err",   m_err,   1'b0);
    check("t3_c2_rdata_hold", m_rdata, 32'hDEAD_BEEF);
`ifdef BUS_ERR_CAPTURE_EN
    check("t3_err_valid", err_valid,      1'b1);
    check("t3_err_addr",  err_addr,       32'h2000_0000);
    check("t3_err_to",    err_is_timeout, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3_err_cleared", err_valid, 1'b0);
`endif

    // 4: slave 3 never ready -> timeout after 16 ACCESS cycles
    m_req = 1'b1; m_addr = 32'h1000_0200;
    tick();
    check("t4_c1_s_req",  s_req,  4'b1000);
    check("t4_c1_s_addr", s_addr, 32'h0);
    for (int k = 2; k <= 16; k++) begin
      tick();
      check($sformatf("t4_c%0d_s_req", k), s_req, 4'b1000);
      check($sformatf("t4_c%0d_ready", k), m_ready, 1'b0);
    end
    tick();
    check("t4_to_s_req", s_req,   4'b0000);
    check("t4_to_ready", m_ready, 1'b1);
    check("t4_to_err",   m_err,   1'b1);
    check("t4_to_rdata", m_rdata, 32'hDEAD_BEEF);
    m_req = 1'b0;
`ifdef BUS_ERR_CAPTURE_EN
    check("t4_err_valid", err_valid,      1'b1);
    check("t4_err_addr",  err_addr,       32'h1000_0200);
    check("t4_err_to",    err_is_timeout, 1'b1);
`endif
    tick();
    check("t4_idle_ready", m_ready, 1'b0);

    // 5: reset during the 2nd wait cycle of a slave 2 access
    m_req = 1'b1; m_addr = 32'h1000_0108;
    tick();
    check("t5_c1_s_req",  s_req,  4'b0100);
    check("t5_c1_s_addr", s_addr, 32'h8);
    tick();
    check("t5_c2_s_req", s_req, 4'b0100);
    reset = 1'b1; m_req = 1'b0;
    #1;
    check("t5_async_s_req", s_req,   4'b0000);
    check("t5_async_ready", m_ready, 1'b0);
    tick();
    tick();
    check("t5_rst_ready",  m_ready, 1'b0);
    check("t5_rst_s_addr", s_addr,  32'h0);
    reset = 1'b0;
    tick();
    check("t5_post_ready", m_ready, 1'b0);
    s_ready = 4'b0100;
    m_req = 1'b1; m_addr = 32'h1000_0100;
    tick();
    check("t5_new_s_req",  s_req,  4'b0100);
    check("t5_new_s_addr", s_addr, 32'h0);
    tick();
    check("t5_new_ready", m_ready, 1'b1);
    check("t5_new_rdata", m_rdata, 32'hCAFE_0002);
    check("t5_new_err",   m_err,   1'b0);
    m_req = 1'b0; s_ready = 4'b0000;
    tick();

    // 6: back-to-back reads, slave 0 then slave 1, m_req held high
    s_rdata[31:0]  = 32'h0A0A_0000;
    s_rdata[63:32] = 32'h0B0B_0001;
    s_ready = 4'b0011;
    m_req = 1'b1; m_addr = 32'h0000_8020;
    tick();
    check("t6_a_s_req",  s_req,  4'b0001);
    check("t6_a_s_addr", s_addr, 32'h20);
    tick();
    check("t6_a_ready", m_ready, 1'b1);
    check("t6_a_rdata", m_rdata, 32'h0A0A_0000);
    check("t6_a_s_req_off", s_req, 4'b0000);
    m_addr = 32'h1000_0008;
    tick();
    check("t6_gap_s_req", s_req,   4'b0000);
    check("t6_gap_ready", m_ready, 1'b0);
    tick();
    check("t6_b_s_req",  s_req,   4'b0010);
    check("t6_b_s_addr", s_addr,  32'h8);
    check("t6_b_ready0", m_ready, 1'b0);
    tick();
    check("t6_b_ready", m_ready, 1'b1);
    check("t6_b_rdata", m_rdata, 32'h0B0B_0001);
    check("t6_b_err",   m_err,   1'b0);
    m_req = 1'b0; s_ready = 4'b0000;
    tick();
    check("t6_end_ready", m_ready, 1'b0);
    check("t6_end_s_req", s_req,   4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_bus_interconnect.md
Name: mmio_bus_interconnect

Overview:
Parametrised N-slave data-side interconnect for the RV32IM core. Replaces the fixed DMEM/GPIO decode with table-driven address regions and a req/ready handshake, so slaves may insert wait states. Adds a timeout and decode-miss bus-error response. Sits between the core's load/store port and the DMEM, GPIO, UART and timer peripherals; the instruction fetch path is out of scope.

Parameters:
NUM_SLAVES, 4, number of slave ports (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
SLV_BASE, {32'h1000_0200, 32'h1000_0100, 32'h1000_0000, 32'h0000_8000}, packed NUM_SLAVES*ADDR_W region bases; slave 0 in LSBs
SLV_MASK, {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_8000}, packed region masks; hit when (addr & mask) == base
TIMEOUT_CYCLES, 16, maximum ACCESS cycles before a bus error (>= 2)
ERR_RDATA, 32'hDEAD_BEEF, m_rdata value returned on any error

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m_req  in  1  master request; held with payload until m_ready
m_we  in  1  1 = write, 0 = read
m_addr  in  ADDR_W  byte address
m_wdata  in  DATA_W  write data
m_wstrb  in  DATA_W/8  byte enables
m_ready  out  1  one-cycle response pulse
m_rdata  out  DATA_W  registered read data, valid with m_ready
m_err  out  1  bus error, valid with m_ready
s_req  out  NUM_SLAVES  one-hot slave request
s_we  out  1  latched write flag
s_addr  out  ADDR_W  latched address, offset = addr & ~mask
s_wdata  out  DATA_W  latched write data
s_wstrb  out  DATA_W/8  latched strobes
s_ready  in  NUM_SLAVES  per-slave completion
s_rdata  in  NUM_SLAVES*DATA_W  per-slave read data

Behaviour:
- Reset (asynchronous): state = IDLE. s_req, m_ready and m_err = 0. m_rdata, s_addr, s_wdata, s_wstrb and s_we = 0. Timeout counter = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, m_req = 1:
  - Decode all regions in parallel. On overlap, the lowest index wins.
  - On a hit: latch idx, we, offset, wdata and wstrb. Go to ACCESS with s_req[idx] = 1 from the next cycle.
  - On a miss: go to RESP with err = 1 and rdata = ERR_RDATA. No s_req is asserted.
- ACCESS:
  - s_req[idx] and the payload are held stable.
  - When s_ready[idx] = 1: capture s_rdata[idx] (zero on writes) and go to RESP with err = 0. s_req drops in the same edge.
  - s_ready from any non-selected slave is ignored.
  - The counter increments every ACCESS cycle. If it reaches TIMEOUT_CYCLES without ready: drop s_req, go to RESP, err = 1, rdata = ERR_RDATA.
- RESP:
  - m_ready = 1 for exactly one cycle, with m_rdata and m_err registered.
  - Then return to IDLE and clear the counter.
  - m_req is not sampled in RESP. The earliest next acceptance is the following IDLE cycle.
- Latency:
  - Zero-wait slave (ready in the first s_req cycle): m_ready 2 cycles after m_req is sampled.
  - Each slave wait state adds 1 cycle.
  - Decode miss: m_ready 1 cycle after sampling.
- Outside RESP, m_rdata holds its last value and m_err = 0.
- Reset asserted mid-ACCESS: s_req drops immediately (asynchronous). No m_ready is issued for the aborted transfer.
- The master must not change its payload while waiting. The block uses only latched copies, so a violation does not affect the transfer in flight.

Optional Feature:
Macro BUS_ERR_CAPTURE_EN.
- Defined: adds ports err_clr (in, 1), err_valid (out, 1), err_addr (out, ADDR_W) and err_is_timeout (out, 1).
  - On the first error while err_valid = 0: capture the full address and set the type flag, then set err_valid.
  - Later errors do not overwrite the capture.
  - err_clr = 1 clears err_valid. If err_clr and a new error coincide in the same cycle, the capture wins.
  - All three outputs reset to 0.
- Undefined: the ports and logic are absent. Response behaviour is identical.

Test Plan:
- Read 0x0000_8010, slave 0 ready on its first s_req cycle, s_rdata0 = 0x1234_5678 -> s_addr = 0x10; m_ready 2 cycles after m_req; m_rdata = 0x1234_5678; m_err = 0.
- Write 0x1000_0004 with data 0xA5A5_A5A5, wstrb 0xF; slave 1 inserts 3 wait states -> s_req = 4'b0010 held for 4 cycles; m_ready at cycle 5; m_err = 0.
- Read 0x2000_0000 (decode miss) -> no s_req bit set; m_ready 1 cycle later with m_err = 1 and m_rdata = 0xDEAD_BEEF.
- Read 0x1000_0200, slave 3 never ready -> s_req[3] deasserts after 16 ACCESS cycles; m_err = 1 with m_rdata = 0xDEAD_BEEF. With the macro: err_addr = 0x1000_0200 and err_is_timeout = 1.
- Reset during the 2nd wait cycle of a slave 2 access -> s_req = 0 asynchronously; no m_ready; a new read to 0x1000_0100 after reset completes normally.
- Back-to-back reads to slaves 0 then 1 with m_req held high -> second s_req asserts exactly 2 cycles after the first m_ready; no overlap of s_req bits.
